conv_input_loader: RTL and testbench

//  Feeds one input window (NUM_SR_ROWS x RAM_SR_DEPTH pixels) from input RAM into the convolution
//  RAM shift-register bank, then issues input_start to the convolution FSM and waits for its

---
 rtl/conv_input_loader.sv | 211 +++++++++++++++++++++
 tb/tb_conv_input_loader.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_input_loader.sv
// ---------------------------------------------------------------------------
// conv_input_loader
//
// Purpose:
//   Streams one input window (NUM_SR_ROWS x RAM_SR_DEPTH pixels) out of the
//   input RAM into the convolution shift-register bank, then kicks the
//   convolution FSM with a one-cycle input_start pulse and waits for its
//   conv_done pulse. One frame is processed per frame_req.
//
//   State flow: IDLE -> FETCH -> DRAIN -> START -> WAIT -> DONE -> IDLE
//   An abort in any non-IDLE state returns straight to IDLE without a
//   frame_done pulse.
//
// Optional feature (compile-time macro):
//   CONV_LOADER_TIMEOUT_EN - adds a watchdog in WAIT. After TIMEOUT_CYCLES
//   cycles without conv_done the loader sets the sticky o_timeout_err flag
//   and returns to IDLE. Without the macro WAIT lasts indefinitely and
//   o_timeout_err is tied low.
//
// Ports:
//   clock             in   rising-edge clock
//   reset             in   asynchronous, active-low reset
//   i_frame_req       in   start a frame (sampled only in IDLE)
//   i_frame_base_addr in   RAM address of first pixel, latched with frame_req
//   i_abort           in   cancel the current frame
//   o_ram_rd_en       out  RAM read strobe
//   o_ram_addr        out  RAM read address (base + idx, wraps silently)
//   i_ram_rd_data     in   RAM read data, valid one cycle after o_ram_rd_en
//   o_sr_load_valid   out  shift one pixel into the SR bank
//   o_sr_load_data    out  pixel to shift in (0 when o_sr_load_valid is 0)
//   o_input_start     out  one-cycle start pulse to the conv FSM
//   i_conv_done       in   completion pulse from the conv FSM
//   o_busy            out  high in every state except IDLE
//   o_frame_done      out  one-cycle pulse, frame completed normally
//   o_timeout_err     out  sticky watchdog flag
// ---------------------------------------------------------------------------
module conv_input_loader #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int RAM_SR_DEPTH   = 4,
  parameter int NUM_SR_ROWS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_frame_req,
  input  logic [ADDR_WIDTH-1:0] i_frame_base_addr,
  input  logic                  i_abort,
  output logic                  o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  output logic                  o_sr_load_valid,
  output logic [DATA_WIDTH-1:0] o_sr_load_data,
  output logic                  o_input_start,
  input  logic                  i_conv_done,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_timeout_err
);

  // Window size; the design assumes TOTAL >= 2 so FETCH has a distinct last index.
  localparam int TOTAL = NUM_SR_ROWS * RAM_SR_DEPTH;
  localparam int IDX_W = $clog2(TOTAL) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_sr_valid;
  logic                  w_timeout;

  // State register. Reset discards any frame in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. Abort is applied last so it overrides conv_done and
  // the watchdog when they land in the same cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_frame_req) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (r_idx == LAST_IDX) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: w_next_state = S_START;
      S_START: w_next_state = S_WAIT;
      S_WAIT: begin
        if (i_conv_done) begin
          w_next_state = S_DONE;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
    end
  end

  // Base address is captured only when a frame is accepted, so the input
  // may change freely while the frame runs. idx counts reads in FETCH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_base <= '0;
      r_idx  <= '0;
    end else if ((r_state == S_IDLE) && i_frame_req) begin
      r_base <= i_frame_base_addr;
      r_idx  <= '0;
    end else if (r_state == S_FETCH) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Load strobe follows the read strobe by one cycle, matching the RAM
  // read latency. An abort kills the pending strobe so nothing is shifted
  // in the cycle after the abort.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sr_valid <= 1'b0;
    end else begin
      r_sr_valid <= (r_state == S_FETCH) && !i_abort;
    end
  end

  // Output decode from the current state.
  always_comb begin
    o_ram_rd_en   = 1'b0;
    o_ram_addr    = '0;
    o_input_start = 1'b0;
    o_frame_done  = 1'b0;
    o_busy        = (r_state != S_IDLE);
    case (r_state)
      S_FETCH: begin
        o_ram_rd_en = 1'b1;
        o_ram_addr  = r_base + ADDR_WIDTH'(r_idx);
      end
      S_START: o_input_start = 1'b1;
      S_DONE:  o_frame_done  = !i_abort;
      default: ;
    endcase
  end

  // Data is forced to zero outside a load so the SR bank never sees stale
  // RAM output.
  assign o_sr_load_valid = r_sr_valid;
  assign o_sr_load_data  = r_sr_valid ? i_ram_rd_data : '0;

`ifdef CONV_LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout_err;

  // Counts cycles spent in WAIT; restarts from zero on every entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_WAIT) && (w_next_state == S_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle.
  assign w_timeout = (r_state == S_WAIT) &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Sticky error: only a reset clears it. conv_done or abort on the
  // timeout cycle take precedence and leave the flag clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout && !i_conv_done && !i_abort) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  logic w_unused_timeout_cfg;

  assign w_timeout            = 1'b0;
  assign o_timeout_err        = 1'b0;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_conv_input_loader.sv
// ---------------------------------------------------------------------------
// tb_conv_input_loader
//
// Directed testbench for conv_input_loader. A small synchronous RAM model
// returns a known function of the address one cycle after each read, so the
// expected pixel stream can be computed from the base address alone.
// Each scenario task drives its own stimulus and checks results inline.
// ---------------------------------------------------------------------------
module tb_conv_input_loader;

`ifdef CONV_LOADER_TIMEOUT_EN
  localparam int TIMEOUT    = 8;
  localparam int CONV_DELAY = 5;
`else
  localparam int TIMEOUT    = 1024;
  localparam int CONV_DELAY = 20;
`endif

  logic        clock     = 1'b0;
  logic        reset     = 1'b0;
  logic        frameReq  = 1'b0;
  logic [15:0] frameBase = 16'h0000;
  logic        abort     = 1'b0;
  logic [7:0]  ramRdData = 8'hEE;
  logic        convDone  = 1'b0;

  logic        ramRdEn;
  logic [15:0] ramAddr;
  logic        srValid;
  logic [7:0]  srData;
  logic        inputStart;
  logic        busy;
  logic        frameDone;
  logic        timeoutErr;

  int nTests = 0;
  int nFail  = 0;

  conv_input_loader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(16),
    .RAM_SR_DEPTH(4),
    .NUM_SR_ROWS(4),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .i_frame_req(frameReq),
    .i_frame_base_addr(frameBase),
    .i_abort(abort),
    .o_ram_rd_en(ramRdEn),
    .o_ram_addr(ramAddr),
    .i_ram_rd_data(ramRdData),
    .o_sr_load_valid(srValid),
    .o_sr_load_data(srData),
    .o_input_start(inputStart),
    .i_conv_done(convDone),
    .o_busy(busy),
    .o_frame_done(frameDone),
    .o_timeout_err(timeoutErr)
  );

  // Pixel value stored at a RAM address.
  function automatic logic [7:0] pix(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always #5 clock = ~clock;

  // RAM model: one-cycle read latency, garbage when not reading.
  always @(posedge clock) begin
    ramRdData <= ramRdEn ? pix(ramAddr) : 8'hEE;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one full frame. Cycle 0 is the frame_req cycle; returns after the
  // frame_done cycle has been checked.
  task automatic run_frame(input string name, input logic [15:0] base, input bit pokeConvDone);
    logic [15:0] expAddr;
    logic [7:0]  expData;
    int          doneCycle;
    doneCycle = 18 + CONV_DELAY;
    tick();
    nTests++;
    if (busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL %s idle_before_req: got busy=%b, expected 0", name, busy);
    end
    frameReq  = 1'b1;
    frameBase = base;
    for (int c = 1; c <= 16; c++) begin
      tick();
      frameReq  = (c == 3);
      frameBase = ~base;
      convDone  = pokeConvDone && (c == 5);
      expAddr   = base + 16'(c - 1);
      nTests++;
      if (ramRdEn !== 1'b1 || ramAddr !== expAddr) begin
        nFail++;
        $display("[TB] FAIL %s fetch_addr c=%0d: got en=%b addr=%h, expected en=1 addr=%h",
                 name, c, ramRdEn, ramAddr, expAddr);
      end
      nTests++;
      if (busy !== 1'b1 || inputStart !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL %s fetch_flags c=%0d: got busy=%b start=%b, expected busy=1 start=0",
                 name, c, busy, inputStart);
      end
      if (c == 1) begin
        nTests++;
        if (srValid !== 1'b0 || srData !== 8'h00) begin
          nFail++;
          $display("[TB] FAIL %s first_fetch_load: got valid=%b data=%h, expected valid=0 data=00",
                   name, srValid, srData);
        end
      end else begin
        expData = pix(base + 16'(c - 2));
        nTests++;
        if (srValid !== 1'b1 || srData !== expData) begin
          nFail++;
          $display("[TB] FAIL %s load c=%0d: got valid=%b data=%h, expected valid=1 data=%h",
                   name, c, srValid, srData, expData);
        end
      end
    end
    // DRAIN
    tick();
    frameReq = 1'b0;
    convDone = 1'b0;
    expData  = pix(base + 16'd15);
    nTests++;
    if (ramRdEn !== 1'b0 || srValid !== 1'b1 || srData !== expData || inputStart !== 1'b0 || busy !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL %s drain: got en=%b valid=%b data=%h start=%b busy=%b, expected en=0 valid=1 data=%h start=0 busy=1",
               name, ramRdEn, srValid, srData, inputStart, busy, expData);
    end
    // START
    tick();
    convDone = pokeConvDone;
    nTests++;
    if (inputStart !== 1'b1 || srValid !== 1'b0 || srData !== 8'h00 || busy !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL %s start: got start=%b valid=%b data=%h busy=%b, expected start=1 valid=0 data=00 busy=1",
               name, inputStart, srValid, srData, busy);
    end
    // WAIT
    for (int c = 19; c <= doneCycle; c++) begin
      tick();
      convDone = (c == doneCycle);
      nTests++;
      if (inputStart !== 1'b0 || frameDone !== 1'b0 || busy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL %s wait c=%0d: got start=%b done=%b busy=%b, expected start=0 done=0 busy=1",
                 name, c, inputStart, frameDone, busy);
      end
    end
    // DONE
    tick();
    convDone = 1'b0;
    nTests++;
    if (frameDone !== 1'b1 || busy !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL %s frame_done: got done=%b busy=%b, expected done=1 busy=1",
               name, frameDone, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    nTests++;
    if ({busy, ramRdEn, ramAddr, srValid, srData, inputStart, frameDone, timeoutErr} !== 31'd0) begin
      nFail++;
      $display("[TB] FAIL reset_held: got busy=%b en=%b addr=%h valid=%b data=%h start=%b done=%b terr=%b, expected all 0",
               busy, ramRdEn, ramAddr, srValid, srData, inputStart, frameDone, timeoutErr);
    end
    reset = 1'b1;
    repeat (3) tick();
    nTests++;
    if ({busy, ramRdEn, ramAddr, srValid, srData, inputStart, frameDone, timeoutErr} !== 31'd0) begin
      nFail++;
      $display("[TB] FAIL reset_released: got busy=%b en=%b addr=%h valid=%b start=%b done=%b, expected all 0",
               busy, ramRdEn, ramAddr, srValid, inputStart, frameDone);
    end
  endtask

  task automatic test_basic();
    run_frame("basic", 16'h0100, 1'b1);
    tick();
    nTests++;
    if (busy !== 1'b0 || frameDone !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL basic_after_done: got busy=%b done=%b, expected busy=0 done=0", busy, frameDone);
    end
  endtask

  task automatic test_wrap();
    run_frame("wrap", 16'hFFF8, 1'b0);
    tick();
    nTests++;
    if (busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL wrap_after_done: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_first", 16'h1234, 1'b0);
    run_frame("b2b_second", 16'h2000, 1'b0);
    tick();
    nTests++;
    if (busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL b2b_after_done: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_abort();
    bit sawActivity;
    tick();
    frameReq  = 1'b1;
    frameBase = 16'h0200;
    for (int c = 1; c <= 4; c++) begin
      tick();
      frameReq = 1'b0;
    end
    tick();
    abort = 1'b1;
    nTests++;
    if (ramRdEn !== 1'b1 || ramAddr !== 16'h0204) begin
      nFail++;
      $display("[TB] FAIL abort_fifth_fetch: got en=%b addr=%h, expected en=1 addr=0204", ramRdEn, ramAddr);
    end
    tick();
    abort = 1'b0;
    nTests++;
    if (ramRdEn !== 1'b0 || srValid !== 1'b0 || srData !== 8'h00 || busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL abort_next_cycle: got en=%b valid=%b data=%h busy=%b, expected all 0",
               ramRdEn, srValid, srData, busy);
    end
    sawActivity = 1'b0;
    repeat (25) begin
      tick();
      if (inputStart !== 1'b0 || frameDone !== 1'b0 || busy !== 1'b0) sawActivity = 1'b1;
    end
    nTests++;
    if (sawActivity !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL abort_quiet: got activity=%b, expected 0", sawActivity);
    end
    run_frame("after_abort", 16'h0300, 1'b0);
    tick();
    nTests++;
    if (busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL after_abort_idle: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_abort_priority();
    tick();
    frameReq  = 1'b1;
    frameBase = 16'h0600;
    for (int c = 1; c <= 18; c++) begin
      tick();
      frameReq = 1'b0;
    end
    tick();
    tick();
    abort    = 1'b1;
    convDone = 1'b1;
    tick();
    abort    = 1'b0;
    convDone = 1'b0;
    nTests++;
    if (busy !== 1'b0 || frameDone !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL abort_over_conv_done: got busy=%b done=%b, expected busy=0 done=0", busy, frameDone);
    end
    tick();
    nTests++;
    if (busy !== 1'b0 || frameDone !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL abort_over_conv_done_late: got busy=%b done=%b, expected busy=0 done=0", busy, frameDone);
    end
  endtask

  task automatic test_reset_mid_wait();
    tick();
    frameReq  = 1'b1;
    frameBase = 16'h0400;
    for (int c = 1; c <= 18; c++) begin
      tick();
      frameReq = 1'b0;
    end
    repeat (3) tick();
    nTests++;
    if (busy !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL mid_wait_busy: got busy=%b, expected 1", busy);
    end
    #2;
    reset = 1'b0;
    #1;
    nTests++;
    if ({busy, ramRdEn, ramAddr, srValid, srData, inputStart, frameDone, timeoutErr} !== 31'd0) begin
      nFail++;
      $display("[TB] FAIL reset_mid_wait: got busy=%b en=%b addr=%h valid=%b start=%b done=%b terr=%b, expected all 0",
               busy, ramRdEn, ramAddr, srValid, inputStart, frameDone, timeoutErr);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    convDone = 1'b1;
    tick();
    convDone = 1'b0;
    nTests++;
    if (busy !== 1'b0 || frameDone !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL conv_done_in_idle: got busy=%b done=%b, expected busy=0 done=0", busy, frameDone);
    end
  endtask

  task automatic test_timeout();
    bit sawBad;
    tick();
    frameReq  = 1'b1;
    frameBase = 16'h0700;
    for (int c = 1; c <= 18; c++) begin
      tick();
      frameReq = 1'b0;
    end
`ifdef CONV_LOADER_TIMEOUT_EN
    for (int w = 1; w <= 8; w++) begin
      tick();
      nTests++;
      if (timeoutErr !== 1'b0 || busy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL timeout_wait w=%0d: got terr=%b busy=%b, expected terr=0 busy=1", w, timeoutErr, busy);
      end
    end
    tick();
    nTests++;
    if (timeoutErr !== 1'b1 || busy !== 1'b0 || frameDone !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL timeout_fire: got terr=%b busy=%b done=%b, expected terr=1 busy=0 done=0",
               timeoutErr, busy, frameDone);
    end
    repeat (5) tick();
    nTests++;
    if (timeoutErr !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL timeout_sticky: got terr=%b, expected 1", timeoutErr);
    end
`else
    sawBad = 1'b0;
    repeat (40) begin
      tick();
      if (busy !== 1'b1 || timeoutErr !== 1'b0 || frameDone !== 1'b0) sawBad = 1'b1;
    end
    nTests++;
    if (sawBad !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL wait_forever: got left_wait=%b, expected 0", sawBad);
    end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    nTests++;
    if (busy !== 1'b0 || frameDone !== 1'b0 || timeoutErr !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL abort_from_wait: got busy=%b done=%b terr=%b, expected all 0", busy, frameDone, timeoutErr);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_abort();
    test_abort_priority();
    test_reset_mid_wait();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
